freelist_multiport: RTL

- Superscalar successor to the single-port physical-register free list.
- Circular FIFO of free physical register indices with ALLOC_W rename-side allocate lanes and FREE_W commit-side release lanes per cycle.
- Allocation is all-or-nothing per cycle; the head pointer is exported for checkpointing and restored on flush.
- Sits between rename (allocate) and ROB commit (free); feeds branch-checkpoint logic.

---
 rtl/freelist_multiport_pkg.sv | 30 +++
 rtl/freelist_multiport_lane_pack.sv | 33 +++
 rtl/freelist_multiport.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/freelist_multiport_pkg.sv
// ---------------------------------------------------------------------------
// CDB_types: shared sizing constants and types for the physical-register
// free list and its neighbours (rename, ROB commit, branch checkpoints).
//
//   P_REG_NUM  number of physical registers
//   A_REG_NUM  number of architectural registers (never free at reset)
//   FL_DEPTH   free-list capacity, must be a power of two
//   preg_t     physical register index
//   fl_ptr_t   free-list pointer, index bits plus one wrap bit
// ---------------------------------------------------------------------------
package CDB_types;

    localparam int unsigned P_REG_NUM = 64;
    localparam int unsigned A_REG_NUM = 32;
    localparam int unsigned FL_DEPTH  = P_REG_NUM - A_REG_NUM;

    localparam int unsigned PREG_W   = $clog2(P_REG_NUM);
    localparam int unsigned FL_IDX_W = $clog2(FL_DEPTH);
    localparam int unsigned PTR_W    = FL_IDX_W + 1;

    typedef logic [PREG_W-1:0]  preg_t;
    typedef logic [FL_IDX_W:0]  fl_ptr_t;
    typedef logic [FL_IDX_W-1:0] fl_idx_t;

    // Array slot addressed by a pointer: drop the wrap bit.
    function automatic fl_idx_t ptr2idx(input fl_ptr_t p);
        return p[FL_IDX_W-1:0];
    endfunction

endpackage

// File: rtl/freelist_multiport_lane_pack.sv
// ---------------------------------------------------------------------------
// freelist_lane_pack: compacts a sparse per-lane valid vector.
//   o_count      popcount of i_valid
//   o_offset[i]  number of valid lanes strictly below lane i, i.e. the rank
//                of lane i among the valid lanes (ascending lane order)
//
// Ports:
//   i_valid   in   W           per-lane valid
//   o_count   out  CNT_W       number of valid lanes
//   o_offset  out  W x CNT_W   exclusive prefix sum of i_valid
// ---------------------------------------------------------------------------
module freelist_lane_pack #(
    parameter int unsigned W     = 2,
    parameter int unsigned CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]            i_valid,
    output logic [CNT_W-1:0]        o_count,
    output logic [W-1:0][CNT_W-1:0] o_offset
);

    logic [CNT_W-1:0] w_acc;

    always_comb begin
        w_acc    = '0;
        o_offset = '0;
        for (int unsigned i = 0; i < W; i++) begin
            o_offset[i] = w_acc;
            w_acc       = w_acc + CNT_W'(i_valid[i]);
        end
        o_count = w_acc;
    end

endmodule

// File: rtl/freelist_multiport.sv
// ---------------------------------------------------------------------------
// freelist_multiport: circular FIFO of free physical register indices with
// ALLOC_W allocate lanes (rename) and FREE_W release lanes (commit) per cycle.
// Allocation is all-or-nothing; the head pointer is exported for branch
// checkpointing and restored from recover_head on flush.
//
// Optional build macro FREELIST_REG_OUT_EN: registers alloc_pd/alloc_ok for
// one-cycle allocate latency (grant and head update stay same-cycle).
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   alloc_req      in   ALLOC_W            per-lane allocate request (sparse)
//   alloc_pd       out  ALLOC_W x preg_t   granted index per requesting lane
//   alloc_ok       out  1                  all requested lanes served
//   free_valid     in   FREE_W             per-lane release valid
//   free_pd        in   FREE_W x preg_t    released indices
//   flush          in   1                  restore head, suppress allocation
//   recover_head   in   fl_ptr_t           checkpointed head
//   fl_head        out  fl_ptr_t           registered head
//   free_count     out  fl_ptr_t           tail - head
//   empty, full    out  1 each             status flags
// ---------------------------------------------------------------------------
module freelist_multiport
    import CDB_types::*;
#(
    parameter int unsigned ALLOC_W = 2,
    parameter int unsigned FREE_W  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ALLOC_W-1:0]        alloc_req,
    output preg_t [ALLOC_W-1:0]       alloc_pd,
    output logic                      alloc_ok,
    input  logic [FREE_W-1:0]         free_valid,
    input  preg_t [FREE_W-1:0]        free_pd,
    input  logic                      flush,
    input  fl_ptr_t                   recover_head,
    output fl_ptr_t                   fl_head,
    output fl_ptr_t                   free_count,
    output logic                      empty,
    output logic                      full
);

    preg_t   r_mem [FL_DEPTH];
    fl_ptr_t r_head;
    fl_ptr_t r_tail;

    fl_ptr_t                 w_alloc_n;
    fl_ptr_t [ALLOC_W-1:0]   w_alloc_off;
    fl_ptr_t                 w_free_n;
    fl_ptr_t [FREE_W-1:0]    w_free_off;

    fl_ptr_t                 w_count;
    logic                    w_grant;
    fl_ptr_t [ALLOC_W-1:0]   w_rd_ptr;
    fl_ptr_t [FREE_W-1:0]    w_wr_ptr;
    preg_t   [ALLOC_W-1:0]   w_pd;

    freelist_lane_pack #(
        .W     (ALLOC_W),
        .CNT_W (PTR_W)
    ) u_alloc_pack (
        .i_valid  (alloc_req),
        .o_count  (w_alloc_n),
        .o_offset (w_alloc_off)
    );

    freelist_lane_pack #(
        .W     (FREE_W),
        .CNT_W (PTR_W)
    ) u_free_pack (
        .i_valid  (free_valid),
        .o_count  (w_free_n),
        .o_offset (w_free_off)
    );

    // rst gates the combinational outputs so an asynchronous reset shows
    // alloc_ok = 0 / alloc_pd = 0 immediately, even with requests pending.
    always_comb begin
        w_count = r_tail - r_head;
        w_grant = !rst && !flush && (w_alloc_n != '0) && (w_count >= w_alloc_n);
        w_rd_ptr = '0;
        w_pd     = '0;
        for (int unsigned i = 0; i < ALLOC_W; i++) begin
            w_rd_ptr[i] = r_head + w_alloc_off[i];
            if (alloc_req[i] && !rst) begin
                w_pd[i] = r_mem[ptr2idx(w_rd_ptr[i])];
            end
        end
        w_wr_ptr = '0;
        for (int unsigned j = 0; j < FREE_W; j++) begin
            w_wr_ptr[j] = r_tail + w_free_off[j];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= fl_ptr_t'(FL_DEPTH);
            for (int unsigned i = 0; i < FL_DEPTH; i++) begin
                r_mem[i] <= preg_t'(A_REG_NUM + i);
            end
        end else begin
            if (flush) begin
                r_head <= recover_head;
            end else if (w_grant) begin
                r_head <= r_head + w_alloc_n;
            end
            // Frees land regardless of flush: commits precede the mispredict.
            r_tail <= r_tail + w_free_n;
            for (int unsigned j = 0; j < FREE_W; j++) begin
                if (free_valid[j]) begin
                    r_mem[ptr2idx(w_wr_ptr[j])] <= free_pd[j];
                end
            end
        end
    end

    assign fl_head    = r_head;
    assign free_count = w_count;
    assign empty      = (w_count == '0);
    assign full       = (w_count == fl_ptr_t'(FL_DEPTH));

`ifdef FREELIST_REG_OUT_EN
    preg_t [ALLOC_W-1:0] r_alloc_pd;
    logic                r_alloc_ok;

    // w_grant already excludes flush, so the registered grant clears on flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alloc_pd <= '0;
            r_alloc_ok <= 1'b0;
        end else begin
            r_alloc_pd <= w_pd;
            r_alloc_ok <= w_grant;
        end
    end

    assign alloc_pd = r_alloc_pd;
    assign alloc_ok = r_alloc_ok;
`else
    assign alloc_pd = w_pd;
    assign alloc_ok = w_grant;
`endif

`ifndef SYNTHESIS
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        (int'(w_count) + int'(w_free_n)) <= int'(FL_DEPTH))
        else $error("freelist overflow: count %0d + frees %0d", w_count, w_free_n);
`endif

endmodule
